// File: rtl/spi_queue_pkg.sv
// Shared types and helpers for the SPI transaction sequencer.
package spi_queue_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // ceil(log2(value)), never below 1 so it can size a vector directly
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// Synchronous show-ahead FIFO; the head word is on dout whenever not empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module spi_word_fifo
  import spi_queue_pkg::*;
#(
  parameter int NUM_DATA_BITS = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [NUM_DATA_BITS-1:0] din,
  output logic [NUM_DATA_BITS-1:0] dout,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = clog2_min1(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     do_push;
  logic                     do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Empty FIFO presents zero rather than stale storage
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_master_queue.sv
// Queues MOSI words, runs one driver transaction per word, collects MISO words.
//
// state     | meaning
// IDLE      | waiting for a queued word, an idle bus and an expired gap
// START     | comm_start high for this single cycle
// WAIT_BUSY | waiting for the driver to drop bus_ready
// WAIT_DONE | waiting for bus_ready to return; then reload the gap counter
module spi_master_queue
  import spi_queue_pkg::*;
#(
  parameter int NUM_DATA_BITS = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int GAP_CYCLES    = 0
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic [NUM_DATA_BITS-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [NUM_DATA_BITS-1:0] rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     rx_overflow,
  output logic                     busy,
  output logic                     comm_start,
  output logic [NUM_DATA_BITS-1:0] mosi_data,
  input  logic                     bus_ready,
  input  logic                     miso_new_data,
  input  logic [NUM_DATA_BITS-1:0] miso_data
);

  localparam int GAP_W = clog2_min1(GAP_CYCLES + 1);

  state_t                   state;
  logic [GAP_W-1:0]         gap_cnt;
  logic                     tx_full;
  logic                     tx_empty;
  logic                     tx_push;
  logic                     tx_pop;
  logic [NUM_DATA_BITS-1:0] tx_head;
  logic                     rx_full;
  logic                     rx_empty;
  logic                     rx_pop;

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign tx_pop   = (state == IDLE) && !tx_empty && bus_ready && (gap_cnt == '0);
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign busy     = (state != IDLE) || !tx_empty;

  spi_word_fifo #(
    .NUM_DATA_BITS(NUM_DATA_BITS),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk  (sys_clk),
    .rst  (rst),
    .push (tx_push),
    .pop  (tx_pop),
    .din  (tx_data),
    .dout (tx_head),
    .full (tx_full),
    .empty(tx_empty)
  );

  spi_word_fifo #(
    .NUM_DATA_BITS(NUM_DATA_BITS),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk  (sys_clk),
    .rst  (rst),
    .push (miso_new_data),
    .pop  (rx_pop),
    .din  (miso_data),
    .dout (rx_data),
    .full (rx_full),
    .empty(rx_empty)
  );

  // Sticky drop flag: a MISO word arrived with no room and no same-cycle read
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_overflow <= 1'b0;
    end else if (miso_new_data && rx_full && !rx_pop) begin
      rx_overflow <= 1'b1;
    end
  end

  // Transaction sequencer with registered comm_start and mosi_data
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      comm_start <= 1'b0;
      mosi_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else if (tx_pop) begin
            mosi_data  <= tx_head;
            comm_start <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          comm_start <= 1'b0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus_ready) begin
            gap_cnt <= GAP_W'(GAP_CYCLES);
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_queue.sv
// Scoreboard bench: stimulus queues expected MOSI/MISO words, monitors compare.
module tb_spi_master_queue;

  logic        clk;
  logic        rst;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_overflow;
  logic        busy;
  logic        comm_start;
  logic [15:0] mosi_data;
  logic        bus_ready;
  logic        miso_new_data;
  logic [15:0] miso_data;

  // slave model drives s_*, test sequence drives m_*
  logic        s_bus, s_new, s_act;
  logic [15:0] s_data;
  logic        m_bus, m_new;
  logic [15:0] m_data;
  logic        slave_en;

  assign bus_ready     = s_bus & m_bus;
  assign miso_new_data = s_new | m_new;
  assign miso_data     = s_new ? s_data : m_data;

  // second instance with a nonzero inter-transaction gap
  logic [15:0] g_tx_data;
  logic        g_tx_valid, g_tx_ready;
  logic [15:0] g_rx_data;
  logic        g_rx_valid, g_rx_ready, g_rx_overflow, g_busy, g_comm_start;
  logic [15:0] g_mosi_data;
  logic        g_bus_ready, g_miso_new;
  logic [15:0] g_miso_data;

  int checks = 0;
  int failures = 0;
  int n_start = 0;

  logic [15:0] exp_mosi[$];
  logic [15:0] exp_rx[$];
  logic [15:0] slave_q[$];

  spi_master_queue #(.NUM_DATA_BITS(16), .FIFO_DEPTH(4), .GAP_CYCLES(0)) dut (
    .sys_clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overflow(rx_overflow), .busy(busy), .comm_start(comm_start),
    .mosi_data(mosi_data), .bus_ready(bus_ready),
    .miso_new_data(miso_new_data), .miso_data(miso_data)
  );

  spi_master_queue #(.NUM_DATA_BITS(16), .FIFO_DEPTH(4), .GAP_CYCLES(3)) dut_g (
    .sys_clk(clk), .rst(rst),
    .tx_data(g_tx_data), .tx_valid(g_tx_valid), .tx_ready(g_tx_ready),
    .rx_data(g_rx_data), .rx_valid(g_rx_valid), .rx_ready(g_rx_ready),
    .rx_overflow(g_rx_overflow), .busy(g_busy), .comm_start(g_comm_start),
    .mosi_data(g_mosi_data), .bus_ready(g_bus_ready),
    .miso_new_data(g_miso_new), .miso_data(g_miso_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // MOSI monitor: every comm_start must match the next queued word on an idle bus
  always @(negedge clk) begin
    if (comm_start) begin
      n_start++;
      chk("start_bus_ready", {31'd0, bus_ready}, 32'd1);
      if (exp_mosi.size() == 0) begin
        chk("unexpected_comm_start", {16'd0, mosi_data}, 32'hffffffff);
      end else begin
        chk("mosi_data", {16'd0, mosi_data}, {16'd0, exp_mosi.pop_front()});
      end
    end
  end

  // RX monitor: every consumed head must match the next expected MISO word
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) begin
        chk("unexpected_rx", {16'd0, rx_data}, 32'hffffffff);
      end else begin
        chk("rx_data", {16'd0, rx_data}, {16'd0, exp_rx.pop_front()});
      end
    end
  end

  // Driver model: busy 3 cycles after each start, then return a MISO word
  always begin
    @(negedge clk);
    if (slave_en && comm_start && !rst) begin
      s_act = 1'b1;
      tick();
      s_bus = 1'b0;
      repeat (3) tick();
      s_data = (slave_q.size() > 0) ? slave_q.pop_front() : 16'hffff;
      s_new = 1'b1;
      s_bus = 1'b1;
      tick();
      s_new = 1'b0;
      s_act = 1'b0;
    end
  end

  task automatic push_word(input logic [15:0] w, input bit expect_tx);
    int n;
    n = 0;
    while (!tx_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("push_timeout", 32'd0, 32'd1);
    if (expect_tx) exp_mosi.push_back(w);
    tx_data  = w;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((busy || s_act || !bus_ready || exp_mosi.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("done_timeout", 32'd0, 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int k;
    rst = 1'b1; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    s_bus = 1'b1; s_new = 1'b0; s_act = 1'b0; s_data = '0;
    m_bus = 1'b1; m_new = 1'b0; m_data = '0; slave_en = 1'b1;
    g_tx_data = '0; g_tx_valid = 1'b0; g_rx_ready = 1'b0;
    g_bus_ready = 1'b1; g_miso_new = 1'b0; g_miso_data = '0;

    // reset state
    tick(); tick();
    chk("rst_comm_start", {31'd0, comm_start}, 32'd0);
    chk("rst_mosi_data", {16'd0, mosi_data}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {16'd0, rx_data}, 32'd0);
    chk("rst_rx_overflow", {31'd0, rx_overflow}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // single word
    slave_q.push_back(16'h4ac5);
    exp_rx.push_back(16'h4ac5);
    push_word(16'h0cf7, 1'b1);
    wait_done();
    chk("single_starts", n_start, 32'd1);
    chk("single_rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("single_rx_head", {16'd0, rx_data}, 32'h4ac5);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    chk("single_rx_drained", {31'd0, rx_valid}, 32'd0);

    // burst of three on consecutive cycles
    n0 = n_start;
    rx_ready = 1'b1;
    slave_q.push_back(16'h4ac5); slave_q.push_back(16'h16fb); slave_q.push_back(16'h35d9);
    exp_rx.push_back(16'h4ac5);  exp_rx.push_back(16'h16fb);  exp_rx.push_back(16'h35d9);
    push_word(16'h0cf7, 1'b1);
    push_word(16'h37e1, 1'b1);
    push_word(16'h2fa0, 1'b1);
    wait_done();
    chk("burst_starts", n_start - n0, 32'd3);
    chk("burst_rx_left", exp_rx.size(), 32'd0);

    // full TX with the bus held busy
    n0 = n_start;
    m_bus = 1'b0;
    push_word(16'h1111, 1'b1);
    push_word(16'h2222, 1'b1);
    push_word(16'h3333, 1'b1);
    chk("tx_ready_before_full", {31'd0, tx_ready}, 32'd1);
    push_word(16'h4444, 1'b1);
    chk("tx_ready_full", {31'd0, tx_ready}, 32'd0);
    tx_data = 16'h5555; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    chk("no_start_bus_low", n_start - n0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      slave_q.push_back(16'h9000 + 16'(i));
      exp_rx.push_back(16'h9000 + 16'(i));
    end
    m_bus = 1'b1;
    wait_done();
    chk("full_starts", n_start - n0, 32'd4);
    chk("full_rx_left", exp_rx.size(), 32'd0);

    // RX overflow
    rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      slave_q.push_back(16'ha000 + 16'(i));
      exp_rx.push_back(16'ha000 + 16'(i));
    end
    push_word(16'he001, 1'b1);
    push_word(16'he002, 1'b1);
    push_word(16'he003, 1'b1);
    push_word(16'he004, 1'b1);
    wait_done();
    chk("ovf_after_4", {31'd0, rx_overflow}, 32'd0);
    chk("ovf_rx_head", {16'd0, rx_data}, 32'ha001);
    exp_rx.push_back(16'ha005);
    m_data = 16'ha005; m_new = 1'b1; rx_ready = 1'b1;
    tick();
    m_new = 1'b0; rx_ready = 1'b0;
    chk("ovf_read_and_write", {31'd0, rx_overflow}, 32'd0);
    slave_q.push_back(16'hb006);
    push_word(16'he005, 1'b1);
    wait_done();
    chk("ovf_set", {31'd0, rx_overflow}, 32'd1);
    rx_ready = 1'b1;
    repeat (6) tick();
    rx_ready = 1'b0;
    chk("ovf_rx_left", exp_rx.size(), 32'd0);
    chk("ovf_rx_empty", {31'd0, rx_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, rx_overflow}, 32'd1);

    // reset mid-transaction
    slave_en = 1'b0;
    n0 = n_start;
    push_word(16'hc001, 1'b1);
    push_word(16'hc002, 1'b0);
    push_word(16'hc003, 1'b0);
    k = 0;
    while (n_start == n0 && k < 50) begin tick(); k++; end
    chk("rstmid_first_start", n_start - n0, 32'd1);
    m_bus = 1'b0;
    tick(); tick();
    m_data = 16'hd1d1; m_new = 1'b1; tick(); m_new = 1'b0;
    chk("rstmid_busy_before", {31'd0, busy}, 32'd1);
    chk("rstmid_rx_before", {31'd0, rx_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rstmid_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_comm_start", {31'd0, comm_start}, 32'd0);
    chk("rstmid_overflow", {31'd0, rx_overflow}, 32'd0);
    m_bus = 1'b1;
    repeat (10) tick();
    chk("rstmid_no_start", n_start - n0, 32'd1);
    slave_en = 1'b1;
    rx_ready = 1'b1;
    slave_q.push_back(16'hd00d);
    exp_rx.push_back(16'hd00d);
    push_word(16'hc004, 1'b1);
    wait_done();
    chk("rstmid_new_start", n_start - n0, 32'd2);
    chk("rstmid_rx_left", exp_rx.size(), 32'd0);

    // gap instance: second start exactly GAP_CYCLES+2 after bus_ready returns
    g_tx_data = 16'h1234; g_tx_valid = 1'b1; tick();
    g_tx_data = 16'h5678; tick();
    g_tx_valid = 1'b0;
    k = 0;
    while (!g_comm_start && k < 20) begin tick(); k++; end
    chk("gap_first_start", {31'd0, g_comm_start}, 32'd1);
    chk("gap_first_mosi", {16'd0, g_mosi_data}, 32'h1234);
    tick(); g_bus_ready = 1'b0;
    tick(); tick();
    g_bus_ready = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (g_comm_start) begin k = i; break; end
    end
    chk("gap_delay", k, 32'd5);
    chk("gap_second_mosi", {16'd0, g_mosi_data}, 32'h5678);

    chk("end_mosi_left", exp_mosi.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_queue.md
# spi_master_queue

Transaction sequencer sitting directly upstream of the SPI master driver. Buffers outgoing MOSI words in a TX FIFO, issues one driver transaction per word whenever the driver reports the bus ready, and collects each returned MISO word into an RX FIFO. This lets the MITM control logic queue bursts of words without tracking the driver's per-transaction handshake.

## Interface
- NUM_DATA_BITS, 16, word width; must match the driver.
- FIFO_DEPTH, 4, entries per FIFO; power of two, ≥2.
- GAP_CYCLES, 0, minimum idle sys_clk cycles between the end of one transaction and the next comm_start.

- sys_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  NUM_DATA_BITS  word to transmit.
- tx_valid  in  1  tx_data valid; word is accepted when tx_valid && tx_ready.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  NUM_DATA_BITS  head of RX FIFO.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  consumer takes the head when rx_valid && rx_ready.
- rx_overflow  out  1  sticky flag: a MISO word was dropped; cleared only by rst.
- busy  out  1  FSM not in IDLE, or TX FIFO non-empty.
- comm_start  out  1  one-cycle start pulse to the driver.
- mosi_data  out  NUM_DATA_BITS  registered word presented to the driver.
- bus_ready  in  1  driver idle.
- miso_new_data  in  1  one-cycle pulse; miso_data is valid this cycle.
- miso_data  in  NUM_DATA_BITS  word received by the driver.

## Operation
- FSM states:
  - IDLE: if TX non-empty && bus_ready && gap counter is 0, pop the TX head into the mosi_data register and go to START.
  - START: comm_start=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: stay until bus_ready==0; go to WAIT_DONE.
  - WAIT_DONE: stay until bus_ready==1; load the gap counter with GAP_CYCLES; go to IDLE.
- Gap counter decrements by one per cycle in IDLE until it reaches 0.
- mosi_data holds its value until the next pop and is stable from START through the end of the transaction.
- RX capture is independent of FSM state. On miso_new_data, the word is written to the RX FIFO if it is not full, or if it is full and a pop occurs in the same cycle. Otherwise the word is discarded and rx_overflow is set.
- TX FIFO:
  - A push while full is impossible, because tx_ready is derived from the registered full flag.
  - Push and pop in the same cycle leave the count unchanged.
  - A pop never occurs in the same cycle a word enters an empty FIFO.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- rx_data and rx_valid are show-ahead: the head is visible without a read strobe.
- Reset mid-transaction: both FIFOs empty, FSM goes to IDLE, and comm_start is low on the next cycle. The driver is reset by the same rst.

## Timing
- Reset values:
  - comm_start=0, mosi_data=0
  - tx_ready=1, rx_valid=0, rx_data=0
  - rx_overflow=0, busy=0
  - gap counter=0
- A word accepted at cycle N with FSM in IDLE and bus_ready=1 is popped at N+1 (mosi_data updates at the end of N+1). comm_start is high at N+2.
- tx_ready falls in the cycle after the push that fills the FIFO. rx_valid rises in the cycle after a write into an empty RX FIFO.
- Back-to-back: next comm_start occurs no earlier than GAP_CYCLES+2 cycles after bus_ready returns high.

## Structure
- Shared package spi_queue_pkg holds:
  - FSM state enum (IDLE, START, WAIT_BUSY, WAIT_DONE);
  - helper function for pointer width (clog2).
- One sub-module, spi_word_fifo: synchronous show-ahead FIFO with parameters NUM_DATA_BITS and FIFO_DEPTH, and ports full, empty, push, pop. It is instantiated twice (TX and RX).

## Test plan
- **Single word:** reset, push 16'h0cf7; slave returns 16'h4ac5.
  - Exactly one comm_start pulse, with mosi_data=16'h0cf7 during it.
  - rx_data=16'h4ac5 and rx_valid=1 after miso_new_data.
- **Burst:** push 16'h0cf7, 16'h37e1, 16'h2fa0 on consecutive cycles; slave returns 16'h4ac5, 16'h16fb, 16'h35d9.
  - Three transactions in order.
  - RX drains in the same order.
  - No comm_start while bus_ready=0.
- **Full TX:** with bus_ready held low, push FIFO_DEPTH+1 words.
  - tx_ready=0 after the 4th word; the 5th is not accepted.
  - Releasing bus_ready sends exactly 4 transactions.
- **RX overflow:** rx_ready=0, run 5 transactions.
  - RX holds the first 4 words; rx_overflow=1 after the 5th.
  - A read and miso_new_data in the same cycle on a full FIFO set no overflow.
- **Gap:** GAP_CYCLES=3, two queued words.
  - Second comm_start occurs exactly 5 cycles after bus_ready returns high.
- **Reset mid-op:** assert rst during WAIT_DONE with 2 words queued.
  - Next cycle: tx_ready=1, rx_valid=0, busy=0, comm_start=0.
  - No further comm_start until a new push.
